// File: rtl/l1_mem_arbiter.sv
// Arbitrates I-cache and D-cache line requests onto one memory port.
// Round-robin on ties, one request in flight, one resp pulse per request.
module l1_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic              r_last_d;
  logic              r_op_write;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_i_resp;
  logic              r_d_resp;
  logic [ADDR_W-1:0] r_mem_address;
  logic [LINE_W-1:0] r_mem_wdata;
  logic [LINE_W-1:0] r_i_rdata;
  logic [LINE_W-1:0] r_d_rdata;

  logic w_i_req;
  logic w_d_req;
  logic w_grant;
  logic w_grant_d;
  logic w_grant_write;
  logic w_op_write_next;
  logic w_mem_read_next;
  logic w_mem_write_next;
  logic w_i_resp_next;
  logic w_d_resp_next;
  logic w_i_capture;
  logic w_d_capture;

  assign w_i_req = i_read | i_write;
  assign w_d_req = d_read | d_write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_grant_d    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_i_req && w_d_req) begin
          w_grant   = 1'b1;
          w_grant_d = ~r_last_d;
        end else if (w_d_req) begin
          w_grant   = 1'b1;
          w_grant_d = 1'b1;
        end else if (w_i_req) begin
          w_grant   = 1'b1;
          w_grant_d = 1'b0;
        end
        if (w_grant) begin
          w_state_next = w_grant_d ? ST_GRANT_D : ST_GRANT_I;
        end
      end
      ST_GRANT_I, ST_GRANT_D: begin
        if (mem_resp) begin
          w_state_next = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state and then registered, so nothing
  // combinational reaches a port.
  always_comb begin
    w_grant_write    = w_grant_d ? d_write : i_write;
    w_op_write_next  = w_grant ? w_grant_write : r_op_write;
    w_mem_read_next  = ((w_state_next == ST_GRANT_I) || (w_state_next == ST_GRANT_D)) && !w_op_write_next;
    w_mem_write_next = ((w_state_next == ST_GRANT_I) || (w_state_next == ST_GRANT_D)) && w_op_write_next;
    w_i_resp_next    = (r_state == ST_GRANT_I) && mem_resp;
    w_d_resp_next    = (r_state == ST_GRANT_D) && mem_resp;
    w_i_capture      = w_i_resp_next && !r_op_write;
    w_d_capture      = w_d_resp_next && !r_op_write;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_d      <= 1'b0;
      r_op_write    <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_i_resp      <= 1'b0;
      r_d_resp      <= 1'b0;
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
      r_i_rdata     <= '0;
      r_d_rdata     <= '0;
    end else begin
      r_mem_read  <= w_mem_read_next;
      r_mem_write <= w_mem_write_next;
      r_i_resp    <= w_i_resp_next;
      r_d_resp    <= w_d_resp_next;
      if (w_grant) begin
        r_last_d      <= w_grant_d;
        r_op_write    <= w_grant_write;
        r_mem_address <= w_grant_d ? d_address : i_address;
        r_mem_wdata   <= w_grant_d ? d_wdata : i_wdata;
      end
      if (w_i_capture) begin
        r_i_rdata <= mem_rdata;
      end
      if (w_d_capture) begin
        r_d_rdata <= mem_rdata;
      end
    end
  end

  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign mem_address = r_mem_address;
  assign mem_wdata   = r_mem_wdata;
  assign i_resp      = r_i_resp;
  assign d_resp      = r_d_resp;
  assign i_rdata     = r_i_rdata;
  assign d_rdata     = r_d_rdata;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Directed scenarios plus randomized traffic for l1_mem_arbiter, checked
// every cycle against a transaction-level model of the arbitration rules.
module tb_l1_mem_arbiter;
  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              i_read = 1'b0, i_write = 1'b0;
  logic [ADDR_W-1:0] i_address = '0;
  logic [LINE_W-1:0] i_wdata = '0;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read = 1'b0, d_write = 1'b0;
  logic [ADDR_W-1:0] d_address = '0;
  logic [LINE_W-1:0] d_wdata = '0;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata = '0;
  logic              mem_resp = 1'b0;

  always #5 clk = ~clk;

  l1_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // memory responder knobs
  int               cfg_wait = 0;
  int               cfg_stretch = 1;
  bit               cfg_rand = 1'b0;
  logic [LINE_W-1:0] cfg_rdata = '0;
  bit               mem_busy = 1'b0;
  int               mem_wait_cnt = 0;
  int               mem_hold = 0;

  // reference model: one outstanding transaction, owner, latched request
  bit               m_active, m_owner_d, m_op_wr, m_cool, m_last_d;
  logic [ADDR_W-1:0] m_addr;
  logic [LINE_W-1:0] m_wdata, m_rd_i, m_rd_d;
  int               n_txn = 0;

  int i_resp_cnt = 0, d_resp_cnt = 0;
  bit rand_clients = 1'b0;
  bit i_busy = 1'b0, d_busy = 1'b0;

  function automatic logic [LINE_W-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0b expected %0b (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic chkv(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int expv);
    n_checks++;
    assert (obs == expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_cool   = 1'b0;
    m_last_d = 1'b0;
    m_rd_i   = '0;
    m_rd_d   = '0;
    mem_busy = 1'b0;
    mem_hold = 0;
    mem_resp = 1'b0;
    i_busy   = 1'b0;
    d_busy   = 1'b0;
  endtask

  task automatic chk_zero(input string pfx);
    chk1({pfx, "_mem_read"}, mem_read, 1'b0);
    chk1({pfx, "_mem_write"}, mem_write, 1'b0);
    chk1({pfx, "_i_resp"}, i_resp, 1'b0);
    chk1({pfx, "_d_resp"}, d_resp, 1'b0);
    chkv({pfx, "_mem_address"}, 128'(mem_address), '0);
    chkv({pfx, "_mem_wdata"}, mem_wdata, '0);
    chkv({pfx, "_i_rdata"}, i_rdata, '0);
    chkv({pfx, "_d_rdata"}, d_rdata, '0);
  endtask

  // One clock: snapshot inputs, cross the edge, advance model, compare,
  // then update the memory responder and clients for the next cycle.
  task automatic tick();
    logic              s_rst, s_ireq, s_dreq, s_iwr, s_dwr, s_mresp;
    logic [ADDR_W-1:0] s_ia, s_da;
    logic [LINE_W-1:0] s_iw, s_dw, s_mrd;
    bit                e_iresp, e_dresp;
    s_rst = reset_n;
    s_ireq = i_read | i_write;  s_iwr = i_write;  s_ia = i_address;  s_iw = i_wdata;
    s_dreq = d_read | d_write;  s_dwr = d_write;  s_da = d_address;  s_dw = d_wdata;
    s_mresp = mem_resp;  s_mrd = mem_rdata;
    @(posedge clk);
    #1;
    cyc++;
    e_iresp = 1'b0;
    e_dresp = 1'b0;
    if (!s_rst) begin
      model_reset();
    end else if (m_active) begin
      if (s_mresp) begin
        m_active = 1'b0;
        m_cool   = 1'b1;
        n_txn++;
        if (m_owner_d) begin
          e_dresp = 1'b1;
          if (!m_op_wr) m_rd_d = s_mrd;
        end else begin
          e_iresp = 1'b1;
          if (!m_op_wr) m_rd_i = s_mrd;
        end
        $display("txn %0d cycle %0d: %s %s addr=%h", n_txn, cyc,
                 m_owner_d ? "D" : "I", m_op_wr ? "write" : "read", m_addr);
      end
    end else if (m_cool) begin
      m_cool = 1'b0;
    end else if (s_ireq || s_dreq) begin
      m_owner_d = (s_ireq && s_dreq) ? !m_last_d : s_dreq;
      m_last_d  = m_owner_d;
      m_active  = 1'b1;
      m_op_wr   = m_owner_d ? s_dwr : s_iwr;
      m_addr    = m_owner_d ? s_da : s_ia;
      m_wdata   = m_owner_d ? s_dw : s_iw;
    end

    chk1("mem_read", mem_read, m_active && !m_op_wr);
    chk1("mem_write", mem_write, m_active && m_op_wr);
    if (m_active) begin
      chkv("mem_address", 128'(mem_address), 128'(m_addr));
      chkv("mem_wdata", mem_wdata, m_wdata);
    end
    chk1("i_resp", i_resp, e_iresp);
    chk1("d_resp", d_resp, e_dresp);
    chkv("i_rdata", i_rdata, m_rd_i);
    chkv("d_rdata", d_rdata, m_rd_d);

    if (i_resp) begin
      i_resp_cnt++;
      i_read = 1'b0; i_write = 1'b0; i_busy = 1'b0;
    end
    if (d_resp) begin
      d_resp_cnt++;
      d_read = 1'b0; d_write = 1'b0; d_busy = 1'b0;
    end

    if (!reset_n) begin
      mem_resp = 1'b0;
      mem_busy = 1'b0;
      mem_hold = 0;
    end else if (mem_hold > 0) begin
      mem_resp  = 1'b1;
      mem_rdata = rand_line();
      mem_hold--;
    end else begin
      mem_resp  = 1'b0;
      mem_rdata = rand_line();
      if ((mem_read || mem_write) && !mem_busy) begin
        mem_busy     = 1'b1;
        mem_wait_cnt = cfg_rand ? int'($urandom_range(0, 3)) : cfg_wait;
      end
      if (mem_busy) begin
        if (mem_wait_cnt == 0) begin
          mem_resp  = 1'b1;
          mem_rdata = cfg_rand ? rand_line() : cfg_rdata;
          mem_hold  = (cfg_rand ? int'($urandom_range(1, 3)) : cfg_stretch) - 1;
          mem_busy  = 1'b0;
        end else begin
          mem_wait_cnt--;
        end
      end
    end

    if (rand_clients) begin
      if (m_active && !m_owner_d && i_busy && $urandom_range(0, 7) == 0) begin
        i_read = 1'b0; i_write = 1'b0;
      end
      if (m_active && m_owner_d && d_busy && $urandom_range(0, 7) == 0) begin
        d_read = 1'b0; d_write = 1'b0;
      end
      if (!i_busy && $urandom_range(0, 2) == 0) begin
        i_busy = 1'b1;
        i_write = $urandom_range(0, 3) == 0;
        i_read = !i_write || ($urandom_range(0, 1) == 1);
        i_address = 16'($urandom());
        i_wdata = rand_line();
      end
      if (!d_busy && $urandom_range(0, 2) == 0) begin
        d_busy = 1'b1;
        d_write = $urandom_range(0, 1) == 0;
        d_read = !d_write || ($urandom_range(0, 3) == 0);
        d_address = 16'($urandom());
        d_wdata = rand_line();
      end
    end
  endtask

  task automatic wait_resp(input bit is_d);
    int k;
    k = 0;
    while (!(is_d ? d_resp : i_resp) && k < 60) begin
      tick();
      k++;
    end
    chk1(is_d ? "d_resp_seen" : "i_resp_seen", is_d ? d_resp : i_resp, 1'b1);
  endtask

  task automatic do_reset();
    i_read = 1'b0; i_write = 1'b0; d_read = 1'b0; d_write = 1'b0;
    reset_n = 1'b0;
    tick();
    chk_zero("rst");
    tick();
    reset_n = 1'b1;
  endtask

  int t0, c0;

  initial begin
    model_reset();
    cfg_rdata = {16{8'hA5}};

    // reset values
    do_reset();

    // single D read, memory waits 3 cycles
    cfg_wait = 3; cfg_stretch = 1;
    d_read = 1'b1; d_address = 16'h1230;
    t0 = cyc;
    tick();
    chk1("d1_mem_read", mem_read, 1'b1);
    chkv("d1_mem_address", 128'(mem_address), 128'(16'h1230));
    wait_resp(1'b1);
    chki("d1_latency", cyc - t0, 5);
    chkv("d1_rdata", d_rdata, {16{8'hA5}});
    chk1("d1_i_resp", i_resp, 1'b0);
    tick();
    chk1("d1_resp_once", d_resp, 1'b0);

    // dirty writeback, then refill requested the cycle after the pulse
    cfg_wait = 0;
    d_write = 1'b1; d_address = 16'h4000;
    d_wdata = 128'h0123456789abcdef_fedcba9876543210;
    tick();
    chk1("wb_mem_write", mem_write, 1'b1);
    chkv("wb_mem_wdata", mem_wdata, 128'h0123456789abcdef_fedcba9876543210);
    wait_resp(1'b1);
    chkv("wb_rdata_kept", d_rdata, {16{8'hA5}});
    tick();
    chk1("refill_idle_gap", mem_read, 1'b0);
    d_read = 1'b1; d_address = 16'h8000;
    tick();
    chk1("refill_mem_read", mem_read, 1'b1);
    chkv("refill_addr", 128'(mem_address), 128'(16'h8000));
    wait_resp(1'b1);

    // simultaneous requests from reset: D first, then tie again with I waiting
    do_reset();
    cfg_wait = 1; cfg_rdata = rand_line();
    i_read = 1'b1; i_address = 16'h1111;
    d_read = 1'b1; d_address = 16'h2222;
    tick();
    chkv("tie1_d_first", 128'(mem_address), 128'(16'h2222));
    wait_resp(1'b1);
    d_read = 1'b1; d_address = 16'h3333;
    tick();
    tick();
    chkv("tie2_i_first", 128'(mem_address), 128'(16'h1111));
    wait_resp(1'b0);
    tick();
    tick();
    chkv("tie2_d_next", 128'(mem_address), 128'(16'h3333));
    wait_resp(1'b1);

    // stretched mem_resp: one pulse, no spurious grant
    cfg_wait = 1; cfg_stretch = 3; cfg_rdata = rand_line();
    c0 = i_resp_cnt;
    i_read = 1'b1; i_address = 16'h5555;
    wait_resp(1'b0);
    repeat (6) tick();
    chki("stretch_pulses", i_resp_cnt - c0, 1);
    chk1("stretch_no_grant", mem_read, 1'b0);
    cfg_stretch = 1;

    // asynchronous reset while I is granted
    cfg_wait = 10;
    i_read = 1'b1; i_address = 16'h7777;
    tick();
    tick();
    chk1("pre_rst_granted", mem_read, 1'b1);
    #2;
    reset_n = 1'b0;
    i_read = 1'b0;
    #1;
    chk_zero("async_rst");
    tick();
    reset_n = 1'b1;
    repeat (4) tick();
    chk1("post_rst_idle", mem_read, 1'b0);

    // client drops its request while granted
    cfg_wait = 3;
    c0 = d_resp_cnt;
    d_read = 1'b1; d_address = 16'h9999;
    tick();
    d_read = 1'b0;
    wait_resp(1'b1);
    tick();
    chki("drop_pulses", d_resp_cnt - c0, 1);

    // randomized traffic
    do_reset();
    cfg_rand = 1'b1;
    rand_clients = 1'b1;
    repeat (2000) tick();
    rand_clients = 1'b0;
    begin
      int k;
      k = 0;
      while ((i_busy || d_busy) && k < 100) begin
        tick();
        k++;
      end
      chk1("drain_done", i_busy || d_busy, 1'b0);
    end
    chk1("txn_count_nonzero", n_txn > 50, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
